// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated edge counter for the ring-oscillator taps.
// Selects one of five oscillator taps, synchronises it into wb_clk_i,
// lets the oscillator settle, then counts rising edges over a
// programmable gate window and reports a saturating count.
module ro_freq_counter #(
   parameter int COUNT_W       = 16,
   parameter int GATE_W        = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic [4:0]         ro_in_i,
   input  logic [2:0]         sel_i,
   input  logic [GATE_W-1:0]  gate_len_i,
   input  logic               start_i,
   output logic               ro_start_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic [COUNT_W-1:0] count_o,
   output logic               overflow_o
);

   localparam int SW = $clog2(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      GATE,
      DONE
   } state_t;

   state_t             state;
   logic [2:0]         sel_q;
   logic [GATE_W-1:0]  gate_rem;
   logic [SW-1:0]      settle_cnt;
   logic [COUNT_W-1:0] edge_cnt;
   logic               sat;
   logic               tap;
   logic               sync1;
   logic               sync2;
   logic               sync3;
   logic               edge_det;
   logic [COUNT_W-1:0] cnt_next;
   logic               sat_next;

   // Tap multiplexer driven by the latched selection; unused codes read as 0.
   always_comb begin
      tap = 1'b0;
      case (sel_q)
         3'd0:    tap = ro_in_i[0];
         3'd1:    tap = ro_in_i[1];
         3'd2:    tap = ro_in_i[2];
         3'd3:    tap = ro_in_i[3];
         3'd4:    tap = ro_in_i[4];
         default: tap = 1'b0;
      endcase
   end

   // Two-flop synchroniser plus a delay flop for rising-edge detection; runs in every state.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= tap;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign edge_det = sync2 & ~sync3;

   // Saturating increment of the edge counter; an increment attempted at max sets the flag.
   always_comb begin
      cnt_next = edge_cnt;
      sat_next = sat;
      if (edge_det) begin
         if (edge_cnt == {COUNT_W{1'b1}}) begin
            sat_next = 1'b1;
         end else begin
            cnt_next = edge_cnt + 1'b1;
         end
      end
   end

   // Measurement sequencer: IDLE -> SETTLE -> GATE -> DONE, with all outputs registered.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state      <= IDLE;
         sel_q      <= 3'd0;
         gate_rem   <= '0;
         settle_cnt <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
         ro_start_o <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         count_o    <= '0;
         overflow_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if ((sel_i <= 3'd4) && (gate_len_i != '0)) begin
                     sel_q      <= sel_i;
                     gate_rem   <= gate_len_i;
                     settle_cnt <= '0;
                     ro_start_o <= 1'b1;
                     busy_o     <= 1'b1;
                     state      <= SETTLE;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                  edge_cnt <= '0;
                  sat      <= 1'b0;
                  state    <= GATE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            GATE: begin
               edge_cnt <= cnt_next;
               sat      <= sat_next;
               if (gate_rem == GATE_W'(1)) begin
                  count_o    <= cnt_next;
                  overflow_o <= sat_next;
                  done_o     <= 1'b1;
                  ro_start_o <= 1'b0;
                  state      <= DONE;
               end else begin
                  gate_rem <= gate_rem - 1'b1;
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Testbench for ro_freq_counter: directed measurements with a scoreboard
// of expected counts for a 16-bit and a 4-bit (saturating) instance.
module tb_ro_freq_counter;

   localparam int S = 8;

   typedef struct {
      int cnt16;
      bit ov16;
      int cnt4;
      bit ov4;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ro_in;
   logic [2:0]  sel_i;
   logic [15:0] gate_len_i;
   logic        start_i;

   logic        ro_start_o, busy_o, done_o, err_o, overflow_o;
   logic [15:0] count_o;
   logic        ro_start_s, busy_s, done_s, err_s, overflow_s;
   logic [3:0]  count_s;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   last16 = 0;
   int   last4  = 0;
   int   period[5];
   int   tick = 0;

   ro_freq_counter #(.COUNT_W(16), .GATE_W(16), .SETTLE_CYCLES(S)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .ro_in_i(ro_in), .sel_i(sel_i),
      .gate_len_i(gate_len_i), .start_i(start_i), .ro_start_o(ro_start_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o),
      .overflow_o(overflow_o)
   );

   ro_freq_counter #(.COUNT_W(4), .GATE_W(16), .SETTLE_CYCLES(S)) dut_sat (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .ro_in_i(ro_in), .sel_i(sel_i),
      .gate_len_i(gate_len_i), .start_i(start_i), .ro_start_o(ro_start_s),
      .busy_o(busy_s), .done_o(done_s), .err_o(err_s), .count_o(count_s),
      .overflow_o(overflow_s)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oscillator tap model: square waves of programmable period, 0 = held low.
   always @(negedge clk) begin
      tick++;
      for (int c = 0; c < 5; c++) begin
         ro_in[c] = (period[c] != 0) && ((tick % period[c]) < (period[c] / 2));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ro_start"}, ro_start_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_err"}, err_o, 0);
      check({tag, "_count"}, count_o, 0);
      check({tag, "_overflow"}, overflow_o, 0);
      check({tag, "_count_sat"}, count_s, 0);
      check({tag, "_ro_start_sat"}, ro_start_s, 0);
   endtask

   // One measurement: optional mid-gate ignored start and optional mid-gate reset.
   task automatic measure(input logic [2:0] s, input logic [15:0] g, input int edges,
                          input bit now, input int inject_at, input int reset_at);
      exp_t e;
      int   m;
      int   ro_hi;
      bit   seen;
      bit   err_seen;
      if (!now) @(negedge clk);
      sel_i      = s;
      gate_len_i = g;
      start_i    = 1'b1;
      if (reset_at == 0) begin
         e.cnt16 = edges;
         e.ov16  = 1'b0;
         e.cnt4  = (edges > 15) ? 15 : edges;
         e.ov4   = (edges > 15);
         exp_q.push_back(e);
      end
      m = 0; ro_hi = 0; seen = 0; err_seen = 0;
      while (!seen && m < S + int'(g) + 20) begin
         @(negedge clk);
         m++;
         if (m == 1) begin
            start_i = 1'b0;
            check("busy_after_start", busy_o, 1);
         end
         if (ro_start_o) ro_hi++;
         if (err_o) err_seen = 1;
         if (inject_at != 0 && m == inject_at) begin
            sel_i = 3'd7; gate_len_i = 16'd5; start_i = 1'b1;
         end
         if (inject_at != 0 && m == inject_at + 1) start_i = 1'b0;
         if (reset_at != 0 && m == reset_at) begin
            check("ro_start_before_reset", ro_start_o, 1);
            #2 rst_n = 1'b0;
            #1 check_all_zero("async_reset");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (done_o) seen = 1;
      end
      check("done_seen", seen, 1);
      if (seen) begin
         check("done_latency", m, S + int'(g) + 1);
         check("ro_start_cycles", ro_hi, S + int'(g));
         check("done_sat_aligned", done_s, 1);
         check("ignored_start_err", err_seen, 0);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("count16", count_o, e.cnt16);
         check("overflow16", overflow_o, e.ov16);
         check("count4", count_s, e.cnt4);
         check("overflow4", overflow_s, e.ov4);
         last16 = e.cnt16;
         last4  = e.cnt4;
      end
   endtask

   // Rejected start: err pulse for exactly one cycle, no busy, results untouched.
   task automatic reject(input logic [2:0] s, input logic [15:0] g);
      @(negedge clk);
      sel_i = s; gate_len_i = g; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("reject_err_pulse", err_o, 1);
      check("reject_busy", busy_o, 0);
      check("reject_ro_start", ro_start_o, 0);
      @(negedge clk);
      check("reject_err_cleared", err_o, 0);
      check("reject_busy_idle", busy_o, 0);
      check("reject_count_held", count_o, last16);
      check("reject_count4_held", count_s, last4);
   endtask

   initial begin
      for (int c = 0; c < 5; c++) period[c] = 0;
      rst_n = 1'b0; start_i = 1'b0; sel_i = 3'd0; gate_len_i = 16'd0;
      ro_in = 5'd0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");

      $display("[TB] nominal measurement, release then immediate start");
      period[2] = 10;
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      measure(3'd2, 16'd100, 10, 1'b1, 0, 0);

      $display("[TB] back-to-back measurement");
      measure(3'd2, 16'd40, 4, 1'b0, 0, 0);

      $display("[TB] start during GATE is ignored");
      measure(3'd2, 16'd100, 10, 1'b0, 50, 0);

      $display("[TB] channel isolation");
      period[2] = 0; period[4] = 8;
      measure(3'd4, 16'd64, 8, 1'b0, 0, 0);
      measure(3'd0, 16'd64, 0, 1'b0, 0, 0);

      $display("[TB] rejected starts");
      reject(3'd5, 16'd10);
      reject(3'd2, 16'd0);
      reject(3'd7, 16'd10);

      $display("[TB] saturation then short run");
      period[4] = 0; period[1] = 4;
      measure(3'd1, 16'd200, 50, 1'b0, 0, 0);
      measure(3'd1, 16'd20, 5, 1'b0, 0, 0);

      $display("[TB] reset mid-gate and restart");
      period[1] = 0; period[2] = 10;
      measure(3'd2, 16'd100, 10, 1'b0, 0, 50);
      measure(3'd2, 16'd100, 10, 1'b1, 0, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
